fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Parametrised instruction fetch/execute sequencer for the mos6502 core; replaces the
//  fixed two-state INF/EX0 control loop. Fetches opcode, then 0..MAX_OPS operand bytes,
//  then runs 1..MAX_EX execute cycles. Owns the program counter and applies the ps_t
//  update (HOLD/INC/REL/ABS) on the last execute cycle. Sits between memory and decode/ALU.
// PARAMETERS
//  ADDR_W    16      address / PC width
//  DATA_W    8       memory data, opcode and operand byte width
//  MAX_OPS   2       max operand bytes per instruction
//  MAX_EX    4       max execute cycles per instruction
//  RESET_PC  'h0000  PC value after reset
// PORTS
//  clk        in   1                    clock, rising edge
//  reset_n    in   1                    async active-low reset
//  en         in   1                    step enable; low = stall, all state holds
//  mem_rdata  in   DATA_W               memory read data (valid same cycle as mem_addr)
//  dec_nops   in   $clog2(MAX_OPS+1)    operand byte count, decoded from ir
//  dec_nex    in   $clog2(MAX_EX+1)     execute cycle count, decoded from ir
//  pc_op      in   2 (ps_t)             PC update applied on last execute cycle
//  rel_off    in   DATA_W               signed branch offset for REL
//  abs_addr   in   ADDR_W               jump target for ABS
//  pc         out  ADDR_W               program counter
//  mem_addr   out  ADDR_W               = pc in FETCH/OPER; undriven-meaning (= pc) in EXEC
//  mm         out  1 (mm_t)             PC_ADDR in FETCH/OPER, A_ADDR in EXEC
//  il         out  1 (il_t)             LOAD in FETCH with en high, else NOLOAD
//  ir         out  DATA_W               instruction register
//  opnd       out  MAX_OPS*DATA_W       operand bytes, byte k at [k*DATA_W +: DATA_W]
//  ex_cnt     out  $clog2(MAX_EX)       current execute cycle index (0-based)
//  in_exec    out  1                    high in EXEC state
//  done       out  1                    one-cycle pulse, registered, after last EXEC cycle
// BEHAVIOUR
//  Reset (async, reset_n=0): state=FETCH, pc=RESET_PC, ir=0, opnd=0, op_cnt=0,
//   ex_cnt=0, done=0. Reset mid-instruction abandons it; no partial PC update.
//  en=0: no register changes (done also forced 0 next edge); outputs reflect held state.
//  Effective counts: nops=min(dec_nops,MAX_OPS); nex=clamp(dec_nex,1,MAX_EX).
//  FETCH: mem_addr=pc. On en: ir<=mem_rdata, pc<=pc+1, op_cnt<=0, go OPER.
//  OPER (decode now valid from new ir):
//   nops==0          -> go EXEC, no fetch, pc unchanged (one decode bubble).
//   op_cnt<nops      -> opnd[op_cnt]<=mem_rdata, pc<=pc+1, op_cnt++;
//                       if op_cnt+1==nops go EXEC, ex_cnt<=0.
//  EXEC: ex_cnt increments each en cycle; on ex_cnt==nex-1:
//   pc per pc_op: HOLD=pc, INC=pc+1, REL=pc+sign_ext(rel_off), ABS=abs_addr;
//   done<=1, go FETCH. Other cycles pc holds.
//  Latency: instruction = 1 + max(nops,1) + nex cycles with en held high.
//  PC arithmetic modulo 2**ADDR_W (wraps 'hFFFF->'h0000 at defaults, both directions).
//  opnd bytes beyond nops keep previous instruction's values (not cleared).
//  Unused state encoding -> FETCH next cycle.
// TESTING
//  1 reset: reset_n=0 mid-EXEC -> pc='h0000, state FETCH, done=0 immediately (async).
//  2 INC, nops=0,nex=1: mem 'h0000='hEA -> ir='hEA, pc='h0002, done pulse at cycle 3.
//  3 ABS, nops=2,nex=2: bytes 4C 34 12, abs_addr='h1234 -> opnd='h1234, pc='h1234 cycle 5.
//  4 REL back: pc='h0010 at EXEC, rel_off='hFE -> pc='h000E; rel_off='h7F -> 'h008F.
//  5 wrap: RESET_PC='hFFFF, nops=1 -> opcode@'hFFFF, operand@'h0000, pc='h0001 in EXEC.
//  6 stall+clamp: en low 3 cycles in OPER -> no change; dec_nex=7 (MAX_EX=4) -> 4 EXEC cycles.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer: opcode fetch, 0..MAX_OPS operand bytes, then
// 1..MAX_EX execute cycles. Owns the program counter and applies the pc_op update at the end.
module fetch_sequencer #(
    parameter int unsigned        ADDR_W   = 16,
    parameter int unsigned        DATA_W   = 8,
    parameter int unsigned        MAX_OPS  = 2,
    parameter int unsigned        MAX_EX   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [DATA_W-1:0]             mem_rdata,
    input  logic [$clog2(MAX_OPS+1)-1:0]  dec_nops,
    input  logic [$clog2(MAX_EX+1)-1:0]   dec_nex,
    input  logic [1:0]                    pc_op,
    input  logic [DATA_W-1:0]             rel_off,
    input  logic [ADDR_W-1:0]             abs_addr,
    output logic [ADDR_W-1:0]             pc,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mm,
    output logic                          il,
    output logic [DATA_W-1:0]             ir,
    output logic [MAX_OPS*DATA_W-1:0]     opnd,
    output logic [$clog2(MAX_EX)-1:0]     ex_cnt,
    output logic                          in_exec,
    output logic                          done
);

    localparam int unsigned OPS_W = $clog2(MAX_OPS + 1);
    localparam int unsigned NEX_W = $clog2(MAX_EX + 1);
    localparam int unsigned EX_W  = $clog2(MAX_EX);

    localparam logic [1:0] StFetch = 2'd0;
    localparam logic [1:0] StOper  = 2'd1;
    localparam logic [1:0] StExec  = 2'd2;

    localparam logic [1:0] PcHold = 2'd0;
    localparam logic [1:0] PcInc  = 2'd1;
    localparam logic [1:0] PcRel  = 2'd2;
    localparam logic [1:0] PcAbs  = 2'd3;

    localparam logic MmPcAddr = 1'b0;
    localparam logic MmAAddr  = 1'b1;
    localparam logic IlNoLoad = 1'b0;
    localparam logic IlLoad   = 1'b1;

    logic [1:0]                state_q, state_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [DATA_W-1:0]         ir_q, ir_d;
    logic [MAX_OPS*DATA_W-1:0] opnd_q, opnd_d;
    logic [OPS_W-1:0]          op_cnt_q, op_cnt_d;
    logic [EX_W-1:0]           ex_cnt_q, ex_cnt_d;
    logic                      done_q, done_d;

    logic [OPS_W-1:0]  nops, op_cnt_inc;
    logic [NEX_W-1:0]  nex, nex_last;
    logic [ADDR_W-1:0] pc_inc, rel_ext, pc_end;
    logic              ex_last;

    always_comb begin
        nops = (dec_nops > OPS_W'(MAX_OPS)) ? OPS_W'(MAX_OPS) : dec_nops;
        if (dec_nex == '0) begin
            nex = NEX_W'(1);
        end else if (dec_nex > NEX_W'(MAX_EX)) begin
            nex = NEX_W'(MAX_EX);
        end else begin
            nex = dec_nex;
        end
        nex_last   = nex - NEX_W'(1);
        // >= rather than == so a decode change mid-instruction still terminates EXEC
        ex_last    = NEX_W'(ex_cnt_q) >= nex_last;
        op_cnt_inc = op_cnt_q + OPS_W'(1);
        pc_inc     = pc_q + ADDR_W'(1);
        rel_ext    = {{(ADDR_W - DATA_W){rel_off[DATA_W-1]}}, rel_off};
        unique case (pc_op)
            PcHold:  pc_end = pc_q;
            PcInc:   pc_end = pc_inc;
            PcRel:   pc_end = pc_q + rel_ext;
            PcAbs:   pc_end = abs_addr;
            default: pc_end = pc_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        opnd_d   = opnd_q;
        op_cnt_d = op_cnt_q;
        ex_cnt_d = ex_cnt_q;
        done_d   = 1'b0;
        case (state_q)
            StFetch: begin
                if (en) begin
                    ir_d     = mem_rdata;
                    pc_d     = pc_inc;
                    op_cnt_d = '0;
                    state_d  = StOper;
                end
            end
            StOper: begin
                if (en) begin
                    if (op_cnt_q < nops) begin
                        for (int unsigned k = 0; k < MAX_OPS; k++) begin
                            if (op_cnt_q == OPS_W'(k)) begin
                                opnd_d[k*DATA_W +: DATA_W] = mem_rdata;
                            end
                        end
                        pc_d     = pc_inc;
                        op_cnt_d = op_cnt_inc;
                        if (op_cnt_inc >= nops) begin
                            state_d  = StExec;
                            ex_cnt_d = '0;
                        end
                    end else begin
                        // No operands: a single decode bubble before EXEC
                        state_d  = StExec;
                        ex_cnt_d = '0;
                    end
                end
            end
            StExec: begin
                if (en) begin
                    if (ex_last) begin
                        pc_d     = pc_end;
                        done_d   = 1'b1;
                        ex_cnt_d = '0;
                        state_d  = StFetch;
                    end else begin
                        ex_cnt_d = ex_cnt_q + EX_W'(1);
                    end
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            opnd_q   <= '0;
            op_cnt_q <= '0;
            ex_cnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            opnd_q   <= opnd_d;
            op_cnt_q <= op_cnt_d;
            ex_cnt_q <= ex_cnt_d;
            done_q   <= done_d;
        end
    end

    assign pc       = pc_q;
    assign mem_addr = pc_q;
    assign mm       = (state_q == StExec) ? MmAAddr : MmPcAddr;
    assign il       = (state_q == StFetch && en) ? IlLoad : IlNoLoad;
    assign ir       = ir_q;
    assign opnd     = opnd_q;
    assign ex_cnt   = ex_cnt_q;
    assign in_exec  = (state_q == StExec);
    assign done     = done_q;

endmodule
